// File: rtl/libhdl_fifo_sc.sv
// Single-clock valid/ready FIFO, any depth >= 2, registered output with write-to-empty bypass.
// Define LIBHDL_FIFO_SC_LEVEL_EN to build the fill counter and the almost-full/almost-empty flags.
module libhdl_fifo_sc #(
  parameter int DATA_LEN         = 32,
  parameter int DEPTH            = 1024,
  parameter int ALMOST_EMPTY_CNT = DEPTH / 4,
  parameter int ALMOST_FULL_CNT  = DEPTH - DEPTH / 4,
  localparam int CNT_LEN         = $clog2(DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_wvld,
  output logic                o_wrdy,
  input  logic [DATA_LEN-1:0] i_wdat,
  output logic                o_wfull,
  output logic                o_walmost_full,
  output logic                o_rvld,
  input  logic                i_rrdy,
  output logic [DATA_LEN-1:0] o_rdat,
  output logic                o_rempty,
  output logic                o_ralmost_empty,
  output logic [CNT_LEN-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Every stored word occupies a memory slot; rd_ptr marks the slot mirrored in the output register.
  logic [DATA_LEN-1:0] mem [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic                wr_wrap_q, wr_wrap_d, wr_wrap_inc;
  logic                rd_wrap_q, rd_wrap_d, rd_wrap_inc;
  logic                rvld_q, rvld_d;
  logic                wfull_q, wfull_d;
  logic [DATA_LEN-1:0] rdat_q, rdat_d;
  logic                wr_en, rd_en, last_word;

  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W-1:0] p, input logic w);
    if (p == PTR_LAST) return {~w, PTR_W'(0)};
    return {w, p + PTR_W'(1)};
  endfunction

  assign o_wrdy   = !wfull_q && !i_rst;
  assign o_wfull  = wfull_q;
  assign o_rvld   = rvld_q;
  assign o_rempty = !rvld_q;
  assign o_rdat   = rdat_q;

  always_comb begin
    {wr_wrap_inc, wr_ptr_inc} = ptr_inc(wr_ptr_q, wr_wrap_q);
    {rd_wrap_inc, rd_ptr_inc} = ptr_inc(rd_ptr_q, rd_wrap_q);
    wr_en     = i_wvld && o_wrdy;
    rd_en     = rvld_q && i_rrdy;
    // The output register holds the only stored word.
    last_word = (rd_ptr_inc == wr_ptr_q) && (rd_wrap_inc == wr_wrap_q);

    wr_ptr_d  = wr_ptr_q;
    wr_wrap_d = wr_wrap_q;
    rd_ptr_d  = rd_ptr_q;
    rd_wrap_d = rd_wrap_q;
    rdat_d    = rdat_q;

    if (i_flush) begin
      wr_ptr_d  = '0;
      wr_wrap_d = 1'b0;
      rd_ptr_d  = '0;
      rd_wrap_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d  = wr_ptr_inc;
        wr_wrap_d = wr_wrap_inc;
      end
      if (rd_en) begin
        rd_ptr_d  = rd_ptr_inc;
        rd_wrap_d = rd_wrap_inc;
      end
      if (wr_en && (!rvld_q || (rd_en && last_word))) begin
        rdat_d = i_wdat;
      end else if (rd_en && !last_word) begin
        rdat_d = mem[rd_ptr_inc];
      end
    end
  end

`ifdef LIBHDL_FIFO_SC_LEVEL_EN
  localparam logic [CNT_LEN-1:0] DEPTH_C = CNT_LEN'(DEPTH);
  localparam logic [CNT_LEN-1:0] AE_C    = CNT_LEN'(ALMOST_EMPTY_CNT);
  localparam logic [CNT_LEN-1:0] AF_C    = CNT_LEN'(ALMOST_FULL_CNT);

  logic [CNT_LEN-1:0] count_q, count_d;
  logic               afull_q, afull_d;
  logic               aempty_q, aempty_d;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (wr_en && !rd_en) begin
      count_d = count_q + CNT_LEN'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_LEN'(1);
    end
    wfull_d  = (count_d == DEPTH_C);
    rvld_d   = (count_d != '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= '0;
      afull_q  <= (ALMOST_FULL_CNT == 0);
      aempty_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign o_count         = count_q;
  assign o_walmost_full  = afull_q;
  assign o_ralmost_empty = aempty_q;
`else
  // Equal pointers mean empty when the wrap flags agree and full when they differ.
  always_comb begin
    wfull_d = (wr_ptr_d == rd_ptr_d) && (wr_wrap_d != rd_wrap_d);
    rvld_d  = !((wr_ptr_d == rd_ptr_d) && (wr_wrap_d == rd_wrap_d));
  end

  assign o_count         = '0;
  assign o_walmost_full  = 1'b0;
  assign o_ralmost_empty = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_ptr_q  <= '0;
      rd_wrap_q <= 1'b0;
      rvld_q    <= 1'b0;
      wfull_q   <= 1'b0;
      rdat_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_wrap_q <= wr_wrap_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_wrap_q <= rd_wrap_d;
      rvld_q    <= rvld_d;
      wfull_q   <= wfull_d;
      rdat_q    <= rdat_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && !i_flush) begin
      mem[wr_ptr_q] <= i_wdat;
    end
  end

endmodule

// File: tb/tb_libhdl_fifo_sc.sv
// Directed bench for libhdl_fifo_sc: a DEPTH=5 instance (fill/drain, full r/w, wrap) and a
// DEPTH=8 instance (bypass, thresholds, steady r/w, flush, reset).
module tb_libhdl_fifo_sc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       a_rst, a_flush, a_wvld, a_wrdy, a_wfull, a_wafull, a_rvld, a_rrdy, a_rempty, a_raempty;
  logic [7:0] a_wdat, a_rdat;
  logic [2:0] a_count;
  logic       b_rst, b_flush, b_wvld, b_wrdy, b_wfull, b_wafull, b_rvld, b_rrdy, b_rempty, b_raempty;
  logic [7:0] b_wdat, b_rdat;
  logic [3:0] b_count;

  libhdl_fifo_sc #(.DATA_LEN(8), .DEPTH(5)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_flush(a_flush), .i_wvld(a_wvld), .o_wrdy(a_wrdy),
    .i_wdat(a_wdat), .o_wfull(a_wfull), .o_walmost_full(a_wafull), .o_rvld(a_rvld),
    .i_rrdy(a_rrdy), .o_rdat(a_rdat), .o_rempty(a_rempty), .o_ralmost_empty(a_raempty),
    .o_count(a_count)
  );

  libhdl_fifo_sc #(.DATA_LEN(8), .DEPTH(8), .ALMOST_EMPTY_CNT(2), .ALMOST_FULL_CNT(6)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush), .i_wvld(b_wvld), .o_wrdy(b_wrdy),
    .i_wdat(b_wdat), .o_wfull(b_wfull), .o_walmost_full(b_wafull), .o_rvld(b_rvld),
    .i_rrdy(b_rrdy), .o_rdat(b_rdat), .o_rempty(b_rempty), .o_ralmost_empty(b_raempty),
    .o_count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int n);
    chk({tag, ".wfull"}, a_wfull, n == 5);
    chk({tag, ".rempty"}, a_rempty, n == 0);
    chk({tag, ".rvld"}, a_rvld, n != 0);
`ifdef LIBHDL_FIFO_SC_LEVEL_EN
    chk({tag, ".count"}, a_count, n);
    chk({tag, ".afull"}, a_wafull, n >= 4);
    chk({tag, ".aempty"}, a_raempty, n <= 1);
`else
    chk({tag, ".count"}, a_count, 0);
    chk({tag, ".afull"}, a_wafull, 0);
    chk({tag, ".aempty"}, a_raempty, 0);
`endif
  endtask

  task automatic chk_b(input string tag, input int n);
    chk({tag, ".wfull"}, b_wfull, n == 8);
    chk({tag, ".rempty"}, b_rempty, n == 0);
    chk({tag, ".rvld"}, b_rvld, n != 0);
`ifdef LIBHDL_FIFO_SC_LEVEL_EN
    chk({tag, ".count"}, b_count, n);
    chk({tag, ".afull"}, b_wafull, n >= 6);
    chk({tag, ".aempty"}, b_raempty, n <= 2);
`else
    chk({tag, ".count"}, b_count, 0);
    chk({tag, ".afull"}, b_wafull, 0);
    chk({tag, ".aempty"}, b_raempty, 0);
`endif
  endtask

  initial begin
    logic [7:0] q[$];
    int sent, got, cyc;
    logic wr, rd;

    a_rst = 1'b1; a_flush = 1'b0; a_wvld = 1'b0; a_rrdy = 1'b0; a_wdat = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_wvld = 1'b0; b_rrdy = 1'b0; b_wdat = '0;
    tick();
    tick();
    chk("a.rst_wrdy", a_wrdy, 0);
    chk("a.rst_rdat", a_rdat, 0);
    chk_a("a.rst", 0);
    chk("b.rst_wrdy", b_wrdy, 0);
    chk("b.rst_rdat", b_rdat, 0);
    chk_b("b.rst", 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    chk("a.post_rst_wrdy", a_wrdy, 1);
    chk("b.post_rst_wrdy", b_wrdy, 1);

    // DEPTH=5: fill, refuse at full, drain in order
    for (int i = 0; i < 5; i++) begin
      a_wvld = 1'b1;
      a_wdat = 8'(8'hA0 + i);
      tick();
      chk_a($sformatf("a.fill%0d", i), i + 1);
    end
    chk("a.full_wrdy", a_wrdy, 0);
    a_wdat = 8'hEE;
    tick();
    chk_a("a.refused", 5);
    a_wvld = 1'b0;
    a_rrdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("a.drain_vld%0d", i), a_rvld, 1);
      chk($sformatf("a.drain_dat%0d", i), a_rdat, 8'(8'hA0 + i));
      tick();
      chk_a($sformatf("a.drain%0d", i), 4 - i);
      if (i == 0) chk("a.full_to_ready", a_wrdy, 1);
    end
    a_rrdy = 1'b0;

    // DEPTH=5: read and write together while full
    for (int i = 0; i < 5; i++) begin
      a_wvld = 1'b1;
      a_wdat = 8'(8'hB0 + i);
      tick();
    end
    chk_a("a.refill", 5);
    a_wdat = 8'hCC;
    a_rrdy = 1'b1;
    chk("a.fullrw_dat", a_rdat, 8'hB0);
    tick();
    chk_a("a.fullrw", 4);
    a_wvld = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("a.fullrw_dat%0d", i), a_rdat, 8'(8'hB0 + i));
      tick();
    end
    chk_a("a.fullrw_end", 0);
    a_rrdy = 1'b0;

    // DEPTH=5: random handshakes across several pointer wraps
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 23 && cyc < 1000) begin
      a_wvld = (sent < 23) && ($urandom_range(0, 1) == 1);
      a_wdat = 8'(8'h30 + sent);
      a_rrdy = ($urandom_range(0, 1) == 1);
      wr = a_wvld && a_wrdy;
      rd = a_rvld && a_rrdy;
      if (rd) begin
        chk($sformatf("a.wrap_dat%0d", got), a_rdat, q[0]);
        void'(q.pop_front());
        got++;
      end
      if (wr) begin
        q.push_back(a_wdat);
        sent++;
      end
      tick();
      cyc++;
      chk_a("a.wrap_lvl", q.size());
    end
    chk("a.wrap_got", got, 23);
    a_wvld = 1'b0;
    a_rrdy = 1'b0;

    // DEPTH=8: bypass into empty FIFO
    b_wvld = 1'b1;
    b_wdat = 8'h55;
    tick();
    b_wvld = 1'b0;
    chk("b.byp_dat", b_rdat, 8'h55);
    chk_b("b.byp", 1);
    b_rrdy = 1'b1;
    tick();
    b_rrdy = 1'b0;
    chk_b("b.byp_rd", 0);

    // DEPTH=8: threshold edges while filling
    for (int i = 0; i < 8; i++) begin
      b_wvld = 1'b1;
      b_wdat = 8'(8'h10 + i);
      tick();
      chk_b($sformatf("b.thr%0d", i + 1), i + 1);
    end
    b_wdat = 8'hEE;
    b_rrdy = 1'b1;
    chk("b.fullrw_dat0", b_rdat, 8'h10);
    tick();
    chk_b("b.fullrw", 7);
    b_wvld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b.rd_dat%0d", i), b_rdat, 8'(8'h11 + i));
      tick();
    end
    chk_b("b.at3", 3);

    // DEPTH=8: sustained read+write at count 3
    b_wvld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_wdat = 8'(8'h20 + i);
      chk($sformatf("b.rw_vld%0d", i), b_rvld, 1);
      chk($sformatf("b.rw_dat%0d", i), b_rdat, (i < 3) ? 8'(8'h15 + i) : 8'(8'h20 + i - 3));
      tick();
      chk_b($sformatf("b.rw%0d", i), 3);
    end
    chk("b.rw_tail", b_rdat, 8'h31);
    b_rrdy = 1'b0;
    b_wdat = 8'h40;
    tick();
    chk_b("b.at4", 4);

    // Flush with concurrent write and read
    b_flush = 1'b1;
    b_wdat  = 8'h41;
    b_rrdy  = 1'b1;
    tick();
    b_flush = 1'b0;
    b_rrdy  = 1'b0;
    chk_b("b.flush", 0);
    b_wdat = 8'h42;
    tick();
    chk("b.post_flush_dat", b_rdat, 8'h42);
    chk_b("b.post_flush", 1);
    b_wdat = 8'h43;
    tick();
    b_wdat = 8'h44;
    tick();
    chk_b("b.pre_rst", 3);

    // Reset mid-stream with handshakes requested
    b_rst  = 1'b1;
    b_wdat = 8'h45;
    b_rrdy = 1'b1;
    #1;
    chk("b.mid_rst_wrdy", b_wrdy, 0);
    tick();
    chk_b("b.mid_rst", 0);
    chk("b.mid_rst_rdat", b_rdat, 0);
    tick();
    chk_b("b.mid_rst2", 0);
    b_rst  = 1'b0;
    b_rrdy = 1'b0;
    b_wdat = 8'h50;
    #1;
    chk("b.post_rst_wrdy", b_wrdy, 1);
    tick();
    b_wvld = 1'b0;
    chk("b.post_rst_dat", b_rdat, 8'h50);
    chk_b("b.post_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/libhdl_fifo_sc.md
# libhdl_fifo_sc

Single-clock synchronous FIFO with valid/ready handshakes on both sides. It supports any integer depth (not only powers of two) and has a registered output with write-to-empty bypass. It also provides a synchronous flush and exact fill-level reporting. It is the same-clock counterpart of the dual-clock FIFO in the fifo component group, for stream buffering inside one clock domain.

## Interface
- DATA_LEN, 32: width of a data word in bits.
- DEPTH, 1024: capacity in words; any integer >= 2.
- ALMOST_EMPTY_CNT, DEPTH/4: almost-empty threshold; legal range 0..DEPTH.
- ALMOST_FULL_CNT, DEPTH - DEPTH/4: almost-full threshold; legal range 0..DEPTH.
- CNT_LEN (localparam), $clog2(DEPTH+1): width of o_count.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_flush  in  1  synchronous discard of all contents.
- i_wvld  in  1  write data valid.
- o_wrdy  out  1  FIFO can accept a word.
- i_wdat  in  DATA_LEN  write data.
- o_wfull  out  1  count == DEPTH.
- o_walmost_full  out  1  count >= ALMOST_FULL_CNT.
- o_rvld  out  1  o_rdat holds the oldest word.
- i_rrdy  in  1  consumer accepts o_rdat.
- o_rdat  out  DATA_LEN  read data, registered.
- o_rempty  out  1  count == 0; always equals !o_rvld.
- o_ralmost_empty  out  1  count <= ALMOST_EMPTY_CNT.
- o_count  out  CNT_LEN  words accepted and not yet read, 0..DEPTH.

## Operation
- Write handshake: o_wrdy && i_wvld at a rising edge. Read handshake: o_rvld && i_rrdy at a rising edge.
- o_wrdy = !o_wfull && !i_rst. It has no combinational dependence on i_rrdy, so a write is refused when full even if a read happens in the same cycle.
- Storage is a DEPTH-word memory plus the output register.
  - The output register holds the oldest word whenever count >= 1.
  - Memory write and read pointers wrap from DEPTH-1 to 0 and support non-power-of-2 DEPTH.
- Write when the output register is empty, or when it is being drained with memory empty: i_wdat loads the output register directly (bypass).
- Read handshake with memory non-empty: the next word is loaded into the output register at the same edge. There is no bubble.
- Count update per edge: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
- Flags are registered and change at the same edge as o_count.
- i_flush at an edge:
  - count goes to 0, o_rvld to 0, and both pointers to 0.
  - Any write or read handshake in that cycle is discarded.
  - The flush takes priority over handshakes. i_rst takes priority over i_flush.
- o_rdat is undefined while o_rvld == 0; benches must not check it then.

## Timing
- Reset values: o_rvld 0, o_rempty 1, o_wfull 0, o_count 0, o_ralmost_empty 1, o_walmost_full (ALMOST_FULL_CNT == 0), o_rdat 0.
- While i_rst is high: o_wrdy = 0. It returns to 1 in the first cycle after i_rst falls.
- Reset mid-operation discards all contents within one edge. Handshakes in the reset cycle are ignored.
- Write-to-read latency on an empty FIFO is 1 cycle: a write at edge k gives o_rvld = 1 and o_rdat = that word after edge k.
- Full-to-ready latency is 1 cycle: a read at edge k while full gives o_wrdy = 1 after edge k.
- Throughput is one write and one read per cycle sustained at any fill level 1..DEPTH-1.

## Configuration
- LIBHDL_FIFO_SC_LEVEL_EN defined:
  - o_count, o_walmost_full and o_ralmost_empty are implemented as above.
  - o_wfull and o_rempty are decoded from the count.
- LIBHDL_FIFO_SC_LEVEL_EN undefined:
  - The counter and threshold logic are removed.
  - o_count, o_walmost_full and o_ralmost_empty are tied to 0.
  - Full and empty are derived from the pointers plus a wrap flag.
  - Handshake, flag timing and data behaviour are cycle-identical to the defined case.

## Test plan
- Fill and drain: DEPTH=5, write 5 words 0xA0..0xA4 with i_rrdy=0 -> o_wfull=1, o_wrdy=0, o_count=5. Then i_rrdy=1 -> words read in order A0..A4 on 5 consecutive cycles, then o_rempty=1.
- Bypass: empty FIFO, single write 0x55 at edge k -> o_rvld=1, o_rdat=0x55 after edge k, o_count=1.
- Simultaneous read and write at count 3 (DEPTH=8) for 20 cycles -> o_count stays 3, no bubble, order preserved. Same test at full -> the write is refused and count drops to DEPTH-1.
- Wrap-around: DEPTH=5, stream 23 words with random i_wvld/i_rrdy -> output sequence equals the input sequence; pointers wrap at 4.
- Thresholds: DEPTH=8, ALMOST_FULL_CNT=6, ALMOST_EMPTY_CNT=2 -> o_walmost_full rises on the 6th write edge, o_ralmost_empty falls on the 3rd write edge.
- Flush at count 4 with a concurrent write -> count 0, o_rvld 0 next cycle, and the next word read is the first word written after the flush. i_rst mid-stream behaves the same, and o_wrdy=0 during reset.
